// File: rtl/led_matrix_scan_driver.sv
// Row-at-a-time scan driver for an 8x8 LED matrix behind two chained 74HC595s.
// Optional macro MATRIX_BRIGHTNESS_EN adds a brightness[3:0] input that PWMs oe_n during the dwell.
module led_matrix_scan_driver #(
    parameter int CLK_DIV     = 4,
    parameter int DWELL       = 2000,
    parameter bit ROW_ACT_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [7:0][7:0] dataMatrix,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [3:0]      brightness,
`endif
    output logic            ds,
    output logic            shcp,
    output logic            stcp,
    output logic            oe_n,
    output logic [2:0]      row_idx,
    output logic            frame_done,
    output logic [2:0]      state_dbg
);

    // The dwell counter is at least 4 bits wide because brightness compares its low nibble.
    localparam int DCW = ($clog2(DWELL) > 4) ? $clog2(DWELL) : 4;
    localparam logic [7:0]     DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_LATCH    = 3'd4,
        S_DWELL    = 3'd5
    } state_t;

    state_t          state;
    logic [7:0][7:0] snap;
    logic [15:0]     word;
    logic [3:0]      bitcnt;
    logic [7:0]      div_cnt;
    logic [DCW-1:0]  dwell_cnt;

    logic [7:0]      rowsel;
    logic [7:0]      row_data;
    logic [15:0]     load_word;
    logic [DCW-1:0]  dwell_next;
    logic            oe_first;
    logic            oe_next;

    assign state_dbg = state;

    always_comb begin
        rowsel = 8'd1 << row_idx;
        if (ROW_ACT_LOW) rowsel = ~rowsel;
        // Row 0 reads the live matrix because the snapshot is captured on that same edge.
        row_data   = (row_idx == 3'd0) ? dataMatrix[0] : snap[row_idx];
        load_word  = {rowsel, row_data};
        dwell_next = dwell_cnt + 1'b1;
`ifdef MATRIX_BRIGHTNESS_EN
        oe_first = (brightness == 4'd0);
        oe_next  = !(dwell_next[3:0] < brightness);
`else
        oe_first = 1'b0;
        oe_next  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            snap       <= '0;
            word       <= '0;
            bitcnt     <= '0;
            div_cnt    <= '0;
            dwell_cnt  <= '0;
            ds         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            oe_n       <= 1'b1;
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    oe_n    <= 1'b1;
                    row_idx <= '0;
                    shcp    <= 1'b0;
                    stcp    <= 1'b0;
                    if (en) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (row_idx == 3'd0) snap <= dataMatrix;
                    word    <= load_word;
                    bitcnt  <= 4'd15;
                    ds      <= load_word[15];
                    shcp    <= 1'b0;
                    div_cnt <= '0;
                    state   <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp    <= 1'b1;
                        state   <= S_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp    <= 1'b0;
                        if (bitcnt == 4'd0) begin
                            // Blank while the new row is latched to avoid ghosting.
                            stcp  <= 1'b1;
                            oe_n  <= 1'b1;
                            state <= S_LATCH;
                        end else begin
                            bitcnt <= bitcnt - 4'd1;
                            ds     <= word[bitcnt - 4'd1];
                            state  <= S_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        stcp      <= 1'b0;
                        dwell_cnt <= '0;
                        oe_n      <= oe_first;
                        state     <= S_DWELL;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        frame_done <= (row_idx == 3'd7);
                        if (en) begin
                            // oe_n is left alone so this row stays lit while the next shifts.
                            row_idx <= row_idx + 3'd1;
                            state   <= S_LOAD;
                        end else begin
                            row_idx <= '0;
                            oe_n    <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_next;
                        oe_n      <= oe_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
